// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use interlock,
// taken-branch squash, data-memory wait states and memory-timeout detection.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock__i,
    input  logic        reset_n__i,
    input  logic [4:0]  IFID_Rs__i,
    input  logic [4:0]  IFID_Rt__i,
    input  logic        IFID_UsesRt__i,
    input  logic        IDEX_MemRead__i,
    input  logic [4:0]  IDEX_Rt__i,
    input  logic        BranchTaken__i,
    input  logic        EXMEM_MemRead__i,
    input  logic        EXMEM_MemWrite__i,
    input  logic        DMemAck__i,
    output logic        DMemReq__o,
    output logic        PCEn__o,
    output logic        IFIDEn__o,
    output logic        IDEXEn__o,
    output logic        EXMEMEn__o,
    output logic        MEMWBEn__o,
    output logic        IFIDFlush__o,
    output logic        IDEXFlush__o,
    output logic        MEMWBFlush__o,
    output logic        MemTimeout__o,
    output logic [15:0] StallCycles__o
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]  wait_cnt_next_s;
    logic [15:0]       stall_cnt_r;

    logic mem_s;
    logic ack_s;
    logic lu_s;
    logic req_s;
    logic advance_s;
    logic freeze_s;
    logic stall_inc_s;

    logic pc_en_s;
    logic ifid_en_s;
    logic idex_en_s;
    logic exmem_en_s;
    logic memwb_en_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic memwb_flush_s;

    assign mem_s = EXMEM_MemRead__i | EXMEM_MemWrite__i;
    // An acknowledge only counts while a request is actually outstanding.
    assign ack_s = DMemAck__i & mem_s;

    assign lu_s = IDEX_MemRead__i & (IDEX_Rt__i != 5'd0) &
                  ((IDEX_Rt__i == IFID_Rs__i) |
                   (IFID_UsesRt__i & (IDEX_Rt__i == IFID_Rt__i)));

    // Next state, wait counter and advance/freeze classification of the cycle.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        advance_s       = 1'b0;
        freeze_s        = 1'b0;
        req_s           = 1'b0;
        case (state_r)
            RUN: begin
                req_s = mem_s;
                if (mem_s & ~ack_s) begin
                    freeze_s        = 1'b1;
                    state_next_s    = MEM_WAIT;
                    wait_cnt_next_s = CNT_ONE;
                end else begin
                    advance_s       = 1'b1;
                    wait_cnt_next_s = CNT_ZERO;
                end
            end
            MEM_WAIT: begin
                req_s = mem_s;
                if (ack_s) begin
                    advance_s       = 1'b1;
                    state_next_s    = RUN;
                    wait_cnt_next_s = CNT_ZERO;
                end else begin
                    freeze_s = 1'b1;
                    // An ack in the cycle where the counter hits the limit is still taken.
                    if (wait_cnt_r == CNT_LIMIT) begin
                        state_next_s = ERROR;
                    end else begin
                        wait_cnt_next_s = wait_cnt_r + CNT_ONE;
                    end
                end
            end
            ERROR: begin
                state_next_s = ERROR;
            end
            default: begin
                state_next_s    = RUN;
                wait_cnt_next_s = CNT_ZERO;
            end
        endcase
    end

    // Register enables and bubble controls for the advance and freeze cases.
    always_comb begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_en_s     = 1'b0;
        exmem_en_s    = 1'b0;
        memwb_en_s    = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        memwb_flush_s = 1'b0;
        if (advance_s) begin
            if (BranchTaken__i) begin
                // The ID instruction is squashed, so a pending load-use is moot.
                pc_en_s      = 1'b1;
                ifid_en_s    = 1'b1;
                idex_en_s    = 1'b1;
                exmem_en_s   = 1'b1;
                memwb_en_s   = 1'b1;
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
            end else if (lu_s) begin
                idex_en_s    = 1'b1;
                exmem_en_s   = 1'b1;
                memwb_en_s   = 1'b1;
                idex_flush_s = 1'b1;
            end else begin
                pc_en_s    = 1'b1;
                ifid_en_s  = 1'b1;
                idex_en_s  = 1'b1;
                exmem_en_s = 1'b1;
                memwb_en_s = 1'b1;
            end
        end else if (freeze_s) begin
            memwb_en_s    = 1'b1;
            memwb_flush_s = 1'b1;
        end else begin
            memwb_en_s    = 1'b0;
            memwb_flush_s = 1'b0;
        end
    end

    assign stall_inc_s = freeze_s | (advance_s & ~BranchTaken__i & lu_s);

    // State register and memory wait counter.
    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_r    <= RUN;
            wait_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Reset forces every control output low immediately, independent of the clock.
    assign DMemReq__o     = req_s         & reset_n__i;
    assign PCEn__o        = pc_en_s       & reset_n__i;
    assign IFIDEn__o      = ifid_en_s     & reset_n__i;
    assign IDEXEn__o      = idex_en_s     & reset_n__i;
    assign EXMEMEn__o     = exmem_en_s    & reset_n__i;
    assign MEMWBEn__o     = memwb_en_s    & reset_n__i;
    assign IFIDFlush__o   = ifid_flush_s  & reset_n__i;
    assign IDEXFlush__o   = idex_flush_s  & reset_n__i;
    assign MEMWBFlush__o  = memwb_flush_s & reset_n__i;
    assign MemTimeout__o  = (state_r == ERROR) & reset_n__i;
    assign StallCycles__o = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven, scoreboarded bench for pipeline_ctrl built with MEM_TIMEOUT=4.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        branch_taken;
    logic        exmem_memread;
    logic        exmem_memwrite;
    logic        dmem_ack;
    logic        dmem_req;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock__i          (clk),
        .reset_n__i        (reset_n),
        .IFID_Rs__i        (ifid_rs),
        .IFID_Rt__i        (ifid_rt),
        .IFID_UsesRt__i    (ifid_uses_rt),
        .IDEX_MemRead__i   (idex_memread),
        .IDEX_Rt__i        (idex_rt),
        .BranchTaken__i    (branch_taken),
        .EXMEM_MemRead__i  (exmem_memread),
        .EXMEM_MemWrite__i (exmem_memwrite),
        .DMemAck__i        (dmem_ack),
        .DMemReq__o        (dmem_req),
        .PCEn__o           (pc_en),
        .IFIDEn__o         (ifid_en),
        .IDEXEn__o         (idex_en),
        .EXMEMEn__o        (exmem_en),
        .MEMWBEn__o        (memwb_en),
        .IFIDFlush__o      (ifid_flush),
        .IDEXFlush__o      (idex_flush),
        .MEMWBFlush__o     (memwb_flush),
        .MemTimeout__o     (mem_timeout),
        .StallCycles__o    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector: {req, pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl, timeout}
    localparam logic [9:0] C_ZERO   = 10'b0000000000;
    localparam logic [9:0] C_IDLE   = 10'b0111110000;
    localparam logic [9:0] C_MEMOK  = 10'b1111110000;
    localparam logic [9:0] C_FREEZE = 10'b1000010010;
    localparam logic [9:0] C_LU     = 10'b0001110100;
    localparam logic [9:0] C_LU_REQ = 10'b1001110100;
    localparam logic [9:0] C_BRANCH = 10'b0111111100;
    localparam logic [9:0] C_ERROR  = 10'b0000000001;

    typedef struct {
        string       name;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        idex_mr;
        logic [4:0]  idex_rt;
        logic        br;
        logic        mr;
        logic        mw;
        logic        ack;
        logic [9:0]  ctl;
        logic [15:0] stall;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   nerr = 0;
    int   nchk = 0;

    function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic idex_mr, input logic [4:0] idex_rt_v,
                                input logic br, input logic mr, input logic mw, input logic ack,
                                input logic [9:0] ctl, input logic [15:0] stall);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.idex_mr = idex_mr;
        v.idex_rt = idex_rt_v; v.br = br; v.mr = mr; v.mw = mw; v.ack = ack;
        v.ctl = ctl; v.stall = stall;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ifid_rs        = v.rs;
        ifid_rt        = v.rt;
        ifid_uses_rt   = v.uses_rt;
        idex_memread   = v.idex_mr;
        idex_rt        = v.idex_rt;
        branch_taken   = v.br;
        exmem_memread  = v.mr;
        exmem_memwrite = v.mw;
        dmem_ack       = v.ack;
        sb.push_back(v);
    endtask

    task automatic check_front();
        vec_t       e;
        logic [9:0] act;
        e   = sb.pop_front();
        act = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, mem_timeout};
        nchk++;
        if (act !== e.ctl) begin
            nerr++;
            $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
        end
        nchk++;
        if (stall_cycles !== e.stall) begin
            nerr++;
            $display("FAIL %s stall: got %0d expected %0d", e.name, stall_cycles, e.stall);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check_front();
    endtask

    // Assert reset asynchronously mid-cycle with the current inputs held, check, then release.
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        sb.push_back(mk(name, ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
                        branch_taken, exmem_memread, exmem_memwrite, dmem_ack, C_ZERO, 16'd0));
        check_front();
        drive(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_ZERO, 16'd0));
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset_n = 1'b0;
        drive(mk("reset_state", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_ZERO, 16'd0));
        #2;
        check_front();
        drive(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_ZERO, 16'd0));
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        //              name          rs     rt     ur    imr   irt    br    mr    mw    ack   ctl       stall
        tbl.push_back(mk("idle0",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   16'd0));
        tbl.push_back(mk("zw_load",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, C_MEMOK,  16'd0));
        tbl.push_back(mk("lu_rs",     5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, C_LU,     16'd0));
        tbl.push_back(mk("lu_r0",     5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   16'd1));
        tbl.push_back(mk("lu_rt",     5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, C_LU,     16'd1));
        tbl.push_back(mk("rt_unused", 5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   16'd2));
        tbl.push_back(mk("br_lu",     5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, C_BRANCH, 16'd2));
        tbl.push_back(mk("idle1",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   16'd2));
        tbl.push_back(mk("st_w1",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 16'd2));
        tbl.push_back(mk("st_w2",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 16'd3));
        tbl.push_back(mk("st_w3",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 16'd4));
        tbl.push_back(mk("st_ack",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, C_MEMOK,  16'd5));
        tbl.push_back(mk("idle2",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   16'd5));
        tbl.push_back(mk("st_w_lu",   5'd9,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 16'd5));
        tbl.push_back(mk("ack_lu",    5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b1, C_LU_REQ, 16'd6));
        tbl.push_back(mk("stray_ack", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, C_IDLE,   16'd7));
        tbl.push_back(mk("idle3",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   16'd7));
        foreach (tbl[i]) step(tbl[i]);

        // Timeout: request from cycle 0 with no ack, error from cycle 5 and held.
        async_reset("rst_before_to");
        for (int c = 0; c < 8; c++) begin
            v = mk($sformatf("to_c%0d", c), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                   (c < 5) ? C_FREEZE : C_ERROR, (c < 5) ? 16'(c) : 16'd5);
            step(v);
        end
        v = mk("err_late_ack", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_ERROR, 16'd5);
        step(v);
        async_reset("rst_in_error");

        // Ack in the cycle where the counter equals the limit is still accepted.
        for (int c = 0; c < 6; c++) begin
            v = mk($sformatf("ack4_c%0d", c), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0,
                   1'b0, (c < 5) ? 1'b1 : 1'b0, (c == 4) ? 1'b1 : 1'b0,
                   (c < 4) ? C_FREEZE : ((c == 4) ? C_MEMOK : C_IDLE),
                   (c < 4) ? 16'(c) : 16'd4);
            step(v);
        end

        // Reset in the middle of a wait, then zero-wait operation from RUN.
        async_reset("rst_pre_mw");
        step(mk("mw_c0", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FREEZE, 16'd0));
        step(mk("mw_c1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FREEZE, 16'd1));
        async_reset("rst_mid_wait");
        step(mk("post_rst_zw", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_MEMOK, 16'd0));
        step(mk("post_rst_idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 16'd0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It takes hazard information from the IF/ID, ID/EX and EX/MEM registers and the data-memory handshake. It then drives the write enables and flush (bubble) controls of the PC and all four pipeline registers, including MEM/WB. It resolves load-use hazards, taken-branch squashes and variable-latency data-memory wait states, and detects memory timeouts.

## Interface
- MEM_TIMEOUT, 15: maximum MEM_WAIT count before error. Legal range is 1..255.
- clock__i  in  1  pipeline clock; all state updates on rising edge.
- reset_n__i  in  1  asynchronous, active-low reset.
- IFID_Rs__i  in  5  rs field of the instruction in ID.
- IFID_Rt__i  in  5  rt field of the instruction in ID.
- IFID_UsesRt__i  in  1  the ID instruction reads rt as a source.
- IDEX_MemRead__i  in  1  the instruction in EX is a load.
- IDEX_Rt__i  in  5  destination register of the load in EX.
- BranchTaken__i  in  1  the branch in EX resolved as taken.
- EXMEM_MemRead__i  in  1  the instruction in MEM is a load.
- EXMEM_MemWrite__i  in  1  the instruction in MEM is a store.
- DMemAck__i  in  1  data memory completes the current access this cycle.
- DMemReq__o  out  1  data memory access request.
- PCEn__o, IFIDEn__o, IDEXEn__o, EXMEMEn__o, MEMWBEn__o  out  1 each  register load enables.
- IFIDFlush__o, IDEXFlush__o, MEMWBFlush__o  out  1 each  load a bubble (all control bits 0) instead of the data input.
- MemTimeout__o  out  1  sticky memory-timeout error.
- StallCycles__o  out  16  saturating count of stalled cycles.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Wait counter: `$clog2(MEM_TIMEOUT+1)` bits, reset 0.
- Memory access: `mem = EXMEM_MemRead__i | EXMEM_MemWrite__i`.
  - `DMemReq__o = mem` in RUN and MEM_WAIT.
  - `DMemReq__o = 0` in ERROR.
- RUN, mem=1, DMemAck__i=1 (zero-wait):
  - No memory stall; hazard rules below apply.
  - Stay in RUN.
- RUN, mem=1, DMemAck__i=0 (memory stall):
  - All enables 0, IFIDFlush__o=0, IDEXFlush__o=0.
  - MEMWBEn__o=1 with MEMWBFlush__o=1, so a bubble enters WB.
  - Next state MEM_WAIT, counter=1.
- MEM_WAIT, DMemAck__i=0:
  - Same freeze outputs as the memory stall above.
  - Counter increments.
  - If counter==MEM_TIMEOUT, next state is ERROR.
- MEM_WAIT, DMemAck__i=1:
  - Outputs as in RUN, with hazard rules evaluated on the current inputs.
  - The pipeline advances this cycle.
  - Next state RUN, counter=0.
- ERROR:
  - All enables 0, all flushes 0, DMemReq__o=0, MemTimeout__o=1.
  - Only reset leaves ERROR.
- Hazard rules, applied only when there is no memory stall (RUN, or MEM_WAIT with ack):
  - Load-use condition: `lu = IDEX_MemRead__i & (IDEX_Rt__i != 0) & ((IDEX_Rt__i == IFID_Rs__i) | (IFID_UsesRt__i & IDEX_Rt__i == IFID_Rt__i))`.
  - BranchTaken__i=1: PCEn__o=1, IFIDFlush__o=1, IDEXFlush__o=1, all other enables 1. Branch overrides lu because the ID instruction is squashed.
  - lu=1 with no branch: PCEn__o=0, IFIDEn__o=0, IDEXFlush__o=1. EXMEMEn__o and MEMWBEn__o are 1.
  - Otherwise: all enables 1, all flushes 0.
- StallCycles__o increments on every cycle that is either a memory-stall/MEM_WAIT-without-ack cycle or an lu stall cycle.
  - Branch flushes do not count.
  - The counter saturates at 0xFFFF and does not count in ERROR.

## Timing
- Control outputs are combinational from state and inputs; there is no added latency.
- Registered state is limited to the state register, the wait counter, StallCycles__o and MemTimeout__o (a function of state).
- Zero-wait access: request and ack in the same cycle, no stall.
- Ack after k unacked cycles: exactly k frozen cycles, and k bubbles enter MEM/WB.
- Timeout: with MEM_TIMEOUT=T, ERROR is entered after T+1 consecutive unacked request cycles. An ack in the cycle where the counter equals T is still accepted.
- While reset_n__i=0:
  - All enables 0, all flushes 0, DMemReq__o=0, MemTimeout__o=0, StallCycles__o=0.
  - State returns to RUN and the counter to 0 immediately, including when reset hits mid-MEM_WAIT or in ERROR.
- No multicycle paths. DMemAck__i is sampled only while DMemReq__o=1; an ack with no request is ignored.

## Test plan
- Zero-wait load: EXMEM_MemRead=1 and DMemAck=1 in the same cycle. Expect DMemReq=1, all enables 1, no flush, StallCycles stays 0.
- Wait states: a store with ack arriving 3 cycles after the request. Expect 3 cycles with all enables 0 except MEMWBEn, MEMWBFlush=1 in those cycles, advance on the ack cycle, StallCycles=3.
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5. Expect PCEn=0, IFIDEn=0, IDEXFlush=1 for one cycle. Repeat with IDEX_Rt=0 and expect no stall.
- Branch plus load-use in the same cycle: expect PCEn=1, IFIDFlush=1, IDEXFlush=1, no stall counted.
- Timeout with MEM_TIMEOUT=4: request from cycle 0 with no ack. Expect MemTimeout=1 and DMemReq=0 from cycle 5, held. A second run with ack at cycle 4 must return to RUN with no error.
- Reset mid-MEM_WAIT: assert reset_n=0 asynchronously. Expect outputs at reset values immediately, and on release, zero-wait operation in RUN.
